// File: rtl/fifo_64.sv
// Single-clock synchronous FIFO with registered read data.
// Flags and occupancy are decoded from the occupancy counter.
module fifo_64 #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 8
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_write,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_read,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_empty,
  output logic                       o_full,
  output logic [$clog2(DEPTH):0]     o_queued
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_rdata;

  logic w_wr_en;
  logic w_rd_en;

  // Acceptance uses the pre-edge count, so a read+write on a full FIFO drops the write.
  always_comb begin
    w_wr_en = i_write && (r_count != FULL_COUNT);
    w_rd_en = i_read  && (r_count != '0);
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge i_clock) begin
    if (!i_reset && w_wr_en) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_rdata <= '0;
    end else begin
      if (w_wr_en) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_rd_en) begin
        r_rdata <= r_mem[r_rptr];
        r_rptr  <= r_rptr + 1'b1;
      end
      if (w_wr_en && !w_rd_en) begin
        r_count <= r_count + 1'b1;
      end else if (w_rd_en && !w_wr_en) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  always_comb begin
    o_rdata  = r_rdata;
    o_empty  = (r_count == '0);
    o_full   = (r_count == FULL_COUNT);
    o_queued = r_count;
  end

endmodule

// File: tb/tb_fifo_64.sv
// Directed bench for fifo_64 at DEPTH=4, WIDTH=8 with hand-computed expectations.
module tb_fifo_64;

  logic       clk;
  logic       rst;
  logic       wr;
  logic [7:0] wdata;
  logic       rd;
  logic [7:0] rdata;
  logic       empty;
  logic       full;
  logic [2:0] queued;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  fifo_64 #(.DEPTH(4), .WIDTH(8)) dut (
    .i_clock  (clk),
    .i_reset  (rst),
    .i_write  (wr),
    .i_wdata  (wdata),
    .i_read   (rd),
    .o_rdata  (rdata),
    .o_empty  (empty),
    .o_full   (full),
    .o_queued (queued)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock with the given strobes, then strobes drop; outputs settle 1ns after the edge.
  task automatic tick(input logic w, input logic [7:0] d, input logic r);
    wr = w; wdata = d; rd = r;
    @(posedge clk);
    #1;
    wr = 1'b0; rd = 1'b0;
  endtask

  task automatic flags(input string tag, input logic e, input logic f, input logic [2:0] q);
    check({tag, ".empty"}, 32'(empty), 32'(e));
    check({tag, ".full"}, 32'(full), 32'(f));
    check({tag, ".queued"}, 32'(queued), 32'(q));
  endtask

  initial begin
    rst = 1'b1; wr = 1'b0; rd = 1'b0; wdata = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    flags("reset", 1'b1, 1'b0, 3'd0);
    check("reset.rdata", 32'(rdata), 32'h00);

    // Single word
    tick(1'b1, 8'hA5, 1'b0);
    flags("single_wr", 1'b0, 1'b0, 3'd1);
    tick(1'b0, 8'h00, 1'b1);
    check("single_rd.rdata", 32'(rdata), 32'hA5);
    flags("single_rd", 1'b1, 1'b0, 3'd0);

    // Fill to full, overflow ignored
    tick(1'b1, 8'h11, 1'b0);
    tick(1'b1, 8'h22, 1'b0);
    tick(1'b1, 8'h33, 1'b0);
    check("fill3.queued", 32'(queued), 32'd3);
    tick(1'b1, 8'h44, 1'b0);
    flags("full", 1'b0, 1'b1, 3'd4);
    tick(1'b1, 8'h55, 1'b0);
    flags("overflow", 1'b0, 1'b1, 3'd4);
    tick(1'b0, 8'h00, 1'b1); check("drain0", 32'(rdata), 32'h11);
    check("drain0.queued", 32'(queued), 32'd3);
    tick(1'b0, 8'h00, 1'b1); check("drain1", 32'(rdata), 32'h22);
    tick(1'b0, 8'h00, 1'b1); check("drain2", 32'(rdata), 32'h33);
    tick(1'b0, 8'h00, 1'b1); check("drain3", 32'(rdata), 32'h44);
    flags("drained", 1'b1, 1'b0, 3'd0);

    // Wrap-around: write 3, read 3, then write 4 across the pointer wrap
    tick(1'b1, 8'hB0, 1'b0);
    tick(1'b1, 8'hB1, 1'b0);
    tick(1'b1, 8'hB2, 1'b0);
    check("wrap_w3.queued", 32'(queued), 32'd3);
    tick(1'b0, 8'h00, 1'b1); check("wrap_r0", 32'(rdata), 32'hB0);
    tick(1'b0, 8'h00, 1'b1); check("wrap_r1", 32'(rdata), 32'hB1);
    tick(1'b0, 8'h00, 1'b1); check("wrap_r2", 32'(rdata), 32'hB2);
    check("wrap_r3.queued", 32'(queued), 32'd0);
    tick(1'b1, 8'hC0, 1'b0);
    tick(1'b1, 8'hC1, 1'b0);
    tick(1'b1, 8'hC2, 1'b0);
    tick(1'b1, 8'hC3, 1'b0);
    flags("wrap_full", 1'b0, 1'b1, 3'd4);
    tick(1'b0, 8'h00, 1'b1); check("wrap_c0", 32'(rdata), 32'hC0);
    check("wrap_c0.queued", 32'(queued), 32'd3);
    tick(1'b0, 8'h00, 1'b1); check("wrap_c1", 32'(rdata), 32'hC1);
    tick(1'b0, 8'h00, 1'b1); check("wrap_c2", 32'(rdata), 32'hC2);
    check("wrap_c2.queued", 32'(queued), 32'd1);
    tick(1'b0, 8'h00, 1'b1); check("wrap_c3", 32'(rdata), 32'hC3);
    flags("wrap_empty", 1'b1, 1'b0, 3'd0);

    // Simultaneous read/write at count=2
    tick(1'b1, 8'hD0, 1'b0);
    tick(1'b1, 8'hD1, 1'b0);
    tick(1'b1, 8'hD2, 1'b1);
    check("rw2.rdata", 32'(rdata), 32'hD0);
    check("rw2.queued", 32'(queued), 32'd2);
    tick(1'b0, 8'h00, 1'b1); check("rw2_d1", 32'(rdata), 32'hD1);
    tick(1'b0, 8'h00, 1'b1); check("rw2_d2", 32'(rdata), 32'hD2);
    flags("rw2_empty", 1'b1, 1'b0, 3'd0);

    // Empty with read+write: no fall-through
    tick(1'b1, 8'hE0, 1'b1);
    check("rw_empty.rdata", 32'(rdata), 32'hD2);
    flags("rw_empty", 1'b0, 1'b0, 3'd1);
    tick(1'b0, 8'h00, 1'b1); check("rw_empty_e0", 32'(rdata), 32'hE0);

    // Full with read+write: write is dropped
    tick(1'b1, 8'hF0, 1'b0);
    tick(1'b1, 8'hF1, 1'b0);
    tick(1'b1, 8'hF2, 1'b0);
    tick(1'b1, 8'hF3, 1'b0);
    check("rw_full_pre.full", 32'(full), 32'd1);
    tick(1'b1, 8'h99, 1'b1);
    check("rw_full.rdata", 32'(rdata), 32'hF0);
    flags("rw_full", 1'b0, 1'b0, 3'd3);
    tick(1'b0, 8'h00, 1'b1); check("rw_full_f1", 32'(rdata), 32'hF1);
    tick(1'b0, 8'h00, 1'b1); check("rw_full_f2", 32'(rdata), 32'hF2);
    tick(1'b0, 8'h00, 1'b1); check("rw_full_f3", 32'(rdata), 32'hF3);
    flags("rw_full_dropped", 1'b1, 1'b0, 3'd0);

    // Read on empty holds the last read word
    tick(1'b1, 8'h7E, 1'b0);
    tick(1'b0, 8'h00, 1'b1); check("hold.rd", 32'(rdata), 32'h7E);
    tick(1'b0, 8'h00, 1'b1);
    check("hold.rdata", 32'(rdata), 32'h7E);
    check("hold.queued", 32'(queued), 32'd0);

    // Reset mid-fill, with a write strobe coincident with reset
    tick(1'b1, 8'h31, 1'b0);
    tick(1'b1, 8'h32, 1'b0);
    check("midfill.queued", 32'(queued), 32'd2);
    rst = 1'b1;
    tick(1'b1, 8'h33, 1'b1);
    rst = 1'b0;
    flags("midreset", 1'b1, 1'b0, 3'd0);
    check("midreset.rdata", 32'(rdata), 32'h00);

    // After reset the FIFO restarts cleanly from pointer 0
    tick(1'b1, 8'h5A, 1'b0);
    tick(1'b0, 8'h00, 1'b1);
    check("post_reset.rdata", 32'(rdata), 32'h5A);
    check("post_reset.queued", 32'(queued), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
